// File: rtl/sw_alloc_mc.sv
// sw_alloc_mc: round-robin switch allocator with forward-and-absorb dual-port grants.
// Grants hold until tail transfer; freed outputs are reusable from the following cycle.
module sw_alloc_mc #(
    parameter int NPORT = 5,
    parameter int PW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT*PW-1:0] port_sel,
    input  logic [NPORT-1:0]    fwdab,
    input  logic [NPORT-1:0]    tail_xfer,
    output logic [NPORT-1:0]    gnt,
    output logic [NPORT-1:0]    gnt_fa,
    output logic [NPORT-1:0]    out_busy,
    output logic [NPORT*PW-1:0] out_src
);
    logic [NPORT-1:0]    gnt_q, gnt_d, gnt_fa_q, gnt_fa_d, busy_q, busy_d;
    logic [NPORT*PW-1:0] src_q, src_d;
    logic [PW-1:0]       rr_q, rr_d;
    logic [NPORT-1:0]    rel, freed, taken, need;
    logic [PW-1:0]       sel;
    logic                any;
    int                  idx, last;

    always_comb begin
        rel    = gnt_q & tail_xfer;
        freed  = '0;
        taken  = '0;
        need   = '0;
        sel    = '0;
        idx    = 0;
        last   = 0;
        any    = 1'b0;
        src_d  = src_q;
        gnt_d  = gnt_q & ~rel;
        gnt_fa_d = gnt_fa_q & ~rel;
        for (int o = 0; o < NPORT; o++)
            for (int i = 0; i < NPORT; i++)
                if (busy_q[o] && src_q[o*PW +: PW] == PW'(i) && rel[i]) freed[o] = 1'b1;
        for (int o = 0; o < NPORT; o++)
            if (freed[o]) src_d[o*PW +: PW] = '0;
        // Eligibility uses registered ownership, so ports freed this edge stay unavailable until the next.
        for (int k = 0; k < NPORT; k++) begin
            idx  = (int'(rr_q) + k) % NPORT;
            sel  = port_sel[idx*PW +: PW];
            need = '0;
            if (int'(sel) < NPORT) begin
                need[sel] = 1'b1;
                need[0]   = need[0] | (fwdab[idx] && sel != '0);
            end
            if (req[idx] && !gnt_q[idx] && need != '0 && (need & (busy_q | taken)) == '0) begin
                taken         = taken | need;
                gnt_d[idx]    = 1'b1;
                gnt_fa_d[idx] = need[0] && sel != '0;
                for (int o = 0; o < NPORT; o++)
                    if (need[o]) src_d[o*PW +: PW] = PW'(idx);
                last = idx;
                any  = 1'b1;
            end
        end
        busy_d = (busy_q & ~freed) | taken;
        rr_d   = any ? PW'((last + 1) % NPORT) : rr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q    <= '0;
            gnt_fa_q <= '0;
            busy_q   <= '0;
            src_q    <= '0;
            rr_q     <= '0;
        end else begin
            gnt_q    <= gnt_d;
            gnt_fa_q <= gnt_fa_d;
            busy_q   <= busy_d;
            src_q    <= src_d;
            rr_q     <= rr_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_fa   = gnt_fa_q;
    assign out_busy = busy_q;
    assign out_src  = src_q;
endmodule

// File: tb/tb_sw_alloc_mc.sv
// tb_sw_alloc_mc: directed checks of grant, hold, release, fwdab and reset behaviour.
module tb_sw_alloc_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req, fwdab, tail_xfer, gnt, gnt_fa, out_busy;
    logic [14:0] port_sel, out_src;
    int          n_cmp = 0;
    int          n_err = 0;

    sw_alloc_mc #(.NPORT(5), .PW(3)) dut (
        .clk(clk), .rst(rst), .req(req), .port_sel(port_sel), .fwdab(fwdab),
        .tail_xfer(tail_xfer), .gnt(gnt), .gnt_fa(gnt_fa), .out_busy(out_busy),
        .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] eg, input logic [4:0] ef,
                           input logic [4:0] eb, input logic [14:0] es);
        chk({tag, ".gnt"}, {11'd0, gnt}, {11'd0, eg});
        chk({tag, ".gnt_fa"}, {11'd0, gnt_fa}, {11'd0, ef});
        chk({tag, ".busy"}, {11'd0, out_busy}, {11'd0, eb});
        chk({tag, ".src"}, {1'b0, out_src}, {1'b0, es});
    endtask

    initial begin
        rst = 1'b1; req = '0; fwdab = '0; tail_xfer = '0; port_sel = '0;
        tick(); tick();
        chk_all("reset", 5'b00000, 5'b00000, 5'b00000, 15'h0);
        rst = 1'b0;
        tick();
        // unicast 2 -> 3
        req[2] = 1'b1; port_sel[6 +: 3] = 3'd3;
        tick();
        chk_all("uni_grant", 5'b00100, 5'b00000, 5'b01000, 15'h0400);
        req[2] = 1'b0;
        tick(); tick();
        chk_all("uni_hold", 5'b00100, 5'b00000, 5'b01000, 15'h0400);
        tail_xfer[2] = 1'b1;
        tick();
        tail_xfer[2] = 1'b0;
        chk_all("uni_release", 5'b00000, 5'b00000, 5'b00000, 15'h0);
        // contention for port 4 from rr_ptr 0
        rst = 1'b1; tick(); rst = 1'b0;
        req = 5'b01010; port_sel = '0; port_sel[3 +: 3] = 3'd4; port_sel[9 +: 3] = 3'd4;
        tick();
        chk_all("cont_first", 5'b00010, 5'b00000, 5'b10000, 15'h1000);
        req[1] = 1'b0; tail_xfer[1] = 1'b1;
        tick();
        tail_xfer[1] = 1'b0;
        chk_all("cont_gap", 5'b00000, 5'b00000, 5'b00000, 15'h0);
        tick();
        chk_all("cont_second", 5'b01000, 5'b00000, 5'b10000, 15'h3000);
        // out-of-range port and tail to ungranted input are ignored
        req[3] = 1'b0; req[1] = 1'b1; port_sel[3 +: 3] = 3'd5; tail_xfer[0] = 1'b1;
        tick(); tick();
        tail_xfer[0] = 1'b0;
        chk_all("bad_port_ignored", 5'b01000, 5'b00000, 5'b10000, 15'h3000);
        req[1] = 1'b0; tail_xfer[3] = 1'b1;
        tick();
        tail_xfer[3] = 1'b0;
        chk_all("cont_release", 5'b00000, 5'b00000, 5'b00000, 15'h0);
        // fwdab 2 blocked while input 4 holds local port
        req[4] = 1'b1; port_sel[12 +: 3] = 3'd0;
        tick();
        chk_all("fa_holder", 5'b10000, 5'b00000, 5'b00001, 15'h0004);
        req[4] = 1'b0; req[2] = 1'b1; fwdab[2] = 1'b1; port_sel[6 +: 3] = 3'd1;
        tick();
        chk_all("fa_blocked", 5'b10000, 5'b00000, 5'b00001, 15'h0004);
        tail_xfer[4] = 1'b1;
        tick();
        tail_xfer[4] = 1'b0;
        chk_all("fa_gap", 5'b00000, 5'b00000, 5'b00000, 15'h0);
        tick();
        chk_all("fa_grant", 5'b00100, 5'b00100, 5'b00011, 15'h0012);
        req[2] = 1'b0; tail_xfer[2] = 1'b1;
        tick();
        tail_xfer[2] = 1'b0; fwdab[2] = 1'b0;
        chk_all("fa_release", 5'b00000, 5'b00000, 5'b00000, 15'h0);
        // same-scan conflict: plain 0->2 beats fwdab 1->2
        rst = 1'b1; tick(); rst = 1'b0;
        req = 5'b00011; fwdab = 5'b00010; port_sel = '0;
        port_sel[0 +: 3] = 3'd2; port_sel[3 +: 3] = 3'd2;
        tick();
        chk_all("scan_conflict", 5'b00001, 5'b00000, 5'b00100, 15'h0000);
        // tail with req still high: input 0 must not be re-granted on the release edge
        tail_xfer[0] = 1'b1;
        tick();
        tail_xfer[0] = 1'b0;
        chk_all("tail_req_release", 5'b00000, 5'b00000, 5'b00000, 15'h0);
        tick();
        chk_all("rr_after_release", 5'b00010, 5'b00010, 5'b00101, 15'h0041);
        // three holders, then reset mid-packet
        req = 5'b01110; port_sel[6 +: 3] = 3'd3; port_sel[9 +: 3] = 3'd4;
        tick();
        chk_all("three_held", 5'b01110, 5'b00010, 5'b11101, 15'h3441);
        req = '0; rst = 1'b1;
        tick();
        rst = 1'b0; fwdab = '0;
        chk_all("reset_mid", 5'b00000, 5'b00000, 5'b00000, 15'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
